sdrc_bram_responder: RTL and testbench



---
 rtl/sdrc_bram_responder.sv | 238 +++++++++++++++++++++++
 tb/tb_sdrc_bram_responder.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdrc_bram_responder.sv
// Block-RAM stand-in for the Gowin SDRAM HS controller user port: cycle-exact
// ack/burst timing for activate, refresh, read and write, plus a sticky misuse flag.
module sdrc_bram_responder #(
    parameter int    DepthBitWidth     = 10,
    parameter int    RamAddressingMode = 2,
    parameter int    InitCycles        = 16,
    parameter int    ActivateAckDelay  = 2,
    parameter int    ReadLatency       = 4,
    parameter int    WriteAckDelay     = 3,
    parameter string MemoryInitFile    = ""
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        I_sdrc_cmd_en,
    input  logic [2:0]  I_sdrc_cmd,
    input  logic        I_sdrc_precharge_ctrl,
    input  logic        I_sdram_power_down,
    input  logic        I_sdram_selfrefresh,
    input  logic [20:0] I_sdrc_addr,
    input  logic [3:0]  I_sdrc_dqm,
    input  logic [31:0] I_sdrc_data,
    input  logic [7:0]  I_sdrc_data_len,
    output logic [31:0] O_sdrc_data,
    output logic        O_sdrc_init_done,
    output logic        O_sdrc_cmd_ack,
    output logic        protocol_error
);

    localparam int Depth    = 1 << DepthBitWidth;
    localparam int ShiftAmt = 2 - RamAddressingMode;
    localparam int MaxA     = (InitCycles > ActivateAckDelay) ? InitCycles : ActivateAckDelay;
    localparam int MaxB     = (ReadLatency > WriteAckDelay) ? ReadLatency : WriteAckDelay;
    localparam int MaxDelay = (MaxA > MaxB) ? MaxA : MaxB;
    localparam int CntW     = $clog2(MaxDelay + 1) + 1;

    localparam logic [2:0] CMD_REFRESH  = 3'b001;
    localparam logic [2:0] CMD_ACTIVATE = 3'b011;
    localparam logic [2:0] CMD_WRITE    = 3'b100;
    localparam logic [2:0] CMD_READ     = 3'b101;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_ACK_WAIT,
        ST_READ_WAIT,
        ST_READ_BURST,
        ST_WRITE_BURST,
        ST_WRITE_ACK
    } state_t;

    state_t                   state_q, state_d;
    logic [CntW-1:0]          cnt_q, cnt_d;
    logic [7:0]               beat_q, beat_d;
    logic [7:0]               len_q, len_d;
    logic [DepthBitWidth-1:0] ptr_q, ptr_d;
    logic                     prech_q, prech_d;
    logic                     row_open_q, row_open_d;
    logic                     err_q, err_d;
    logic [31:0]              data_q;

    logic [DepthBitWidth-1:0] in_idx;
    logic                     wr_en, rd_en, cmd_ack;
    logic [DepthBitWidth-1:0] wr_idx, rd_idx;

    logic [31:0] mem_q [Depth];

    assign in_idx = DepthBitWidth'(I_sdrc_addr >> ShiftAmt);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        beat_d     = beat_q;
        len_d      = len_q;
        ptr_d      = ptr_q;
        prech_d    = prech_q;
        row_open_d = row_open_q;
        err_d      = err_q;
        wr_en      = 1'b0;
        wr_idx     = ptr_q;
        rd_en      = 1'b0;
        rd_idx     = ptr_q;
        cmd_ack    = 1'b0;

        // Commands outside Idle (including during Init) are dropped but flagged.
        if (I_sdrc_cmd_en && (state_q != ST_IDLE)) err_d = 1'b1;
        if (I_sdram_power_down || I_sdram_selfrefresh) err_d = 1'b1;

        case (state_q)
            ST_INIT: begin
                if (cnt_q == CntW'(InitCycles - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (I_sdrc_cmd_en) begin
                    len_d   = I_sdrc_data_len;
                    prech_d = I_sdrc_precharge_ctrl;
                    beat_d  = 8'd1;
                    cnt_d   = CntW'(1);
                    case (I_sdrc_cmd)
                        CMD_READ: begin
                            if (!row_open_q) err_d = 1'b1;
                            if (ReadLatency == 1) begin
                                rd_en   = 1'b1;
                                rd_idx  = in_idx;
                                ptr_d   = in_idx + 1'b1;
                                beat_d  = 8'd0;
                                state_d = ST_READ_BURST;
                            end else begin
                                ptr_d   = in_idx;
                                state_d = ST_READ_WAIT;
                            end
                        end
                        CMD_WRITE: begin
                            if (!row_open_q) err_d = 1'b1;
                            wr_en  = 1'b1;
                            wr_idx = in_idx;
                            ptr_d  = in_idx + 1'b1;
                            if (I_sdrc_data_len == 8'd0) begin
                                state_d = ST_WRITE_ACK;
                                if (I_sdrc_precharge_ctrl) row_open_d = 1'b0;
                            end else begin
                                state_d = ST_WRITE_BURST;
                            end
                        end
                        CMD_ACTIVATE: begin
                            if (row_open_q) err_d = 1'b1;
                            row_open_d = 1'b1;
                            state_d    = ST_ACK_WAIT;
                        end
                        CMD_REFRESH: begin
                            row_open_d = 1'b0;
                            state_d    = ST_ACK_WAIT;
                        end
                        default: state_d = ST_ACK_WAIT;
                    endcase
                end
            end
            ST_ACK_WAIT: begin
                if (cnt_q == CntW'(ActivateAckDelay)) begin
                    cmd_ack = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_READ_WAIT: begin
                // The RAM read is issued one cycle early so the registered beat lands on time.
                if (cnt_q == CntW'(ReadLatency - 1)) begin
                    rd_en   = 1'b1;
                    ptr_d   = ptr_q + 1'b1;
                    beat_d  = 8'd0;
                    state_d = ST_READ_BURST;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_READ_BURST: begin
                if (beat_q == len_q) begin
                    state_d = ST_IDLE;
                    if (prech_q) row_open_d = 1'b0;
                end else begin
                    rd_en  = 1'b1;
                    ptr_d  = ptr_q + 1'b1;
                    beat_d = beat_q + 1'b1;
                end
            end
            ST_WRITE_BURST: begin
                wr_en = 1'b1;
                ptr_d = ptr_q + 1'b1;
                if (beat_q == len_q) begin
                    state_d = ST_WRITE_ACK;
                    cnt_d   = CntW'(1);
                    if (prech_q) row_open_d = 1'b0;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            ST_WRITE_ACK: begin
                if (cnt_q == CntW'(WriteAckDelay)) begin
                    cmd_ack = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            cnt_q      <= '0;
            beat_q     <= '0;
            row_open_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            beat_q     <= beat_d;
            row_open_q <= row_open_d;
            err_q      <= err_d;
        end
    end

    // Burst bookkeeping is only meaningful once a command has been accepted.
    always_ff @(posedge clk) begin
        len_q   <= len_d;
        ptr_q   <= ptr_d;
        prech_q <= prech_d;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (!I_sdrc_dqm[b]) mem_q[wr_idx][8*b +: 8] <= I_sdrc_data[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else if (rd_en) begin
            data_q <= mem_q[rd_idx];
        end
    end

    assign O_sdrc_data      = data_q;
    assign O_sdrc_init_done = (state_q != ST_INIT);
    assign O_sdrc_cmd_ack   = cmd_ack;
    assign protocol_error   = err_q;

endmodule

// File: tb/tb_sdrc_bram_responder.sv
// Bench for sdrc_bram_responder: command table plus reset/overlap sequences,
// checked cycle by cycle against a scoreboard of expected acks and read beats.
module tb_sdrc_bram_responder;

    localparam int DW    = 10;
    localparam int MODE  = 2;
    localparam int INIT  = 16;
    localparam int AAD   = 2;
    localparam int RL    = 4;
    localparam int WAD   = 3;
    localparam int DEPTH = 1 << DW;
    localparam int NEVER = 1 << 30;

    localparam logic [2:0] C_REF = 3'b001;
    localparam logic [2:0] C_ACT = 3'b011;
    localparam logic [2:0] C_WR  = 3'b100;
    localparam logic [2:0] C_RD  = 3'b101;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        I_sdrc_cmd_en = 1'b0;
    logic [2:0]  I_sdrc_cmd = 3'b000;
    logic        I_sdrc_precharge_ctrl = 1'b0;
    logic        I_sdram_power_down = 1'b0;
    logic        I_sdram_selfrefresh = 1'b0;
    logic [20:0] I_sdrc_addr = '0;
    logic [3:0]  I_sdrc_dqm = '0;
    logic [31:0] I_sdrc_data = '0;
    logic [7:0]  I_sdrc_data_len = '0;
    logic [31:0] O_sdrc_data;
    logic        O_sdrc_init_done;
    logic        O_sdrc_cmd_ack;
    logic        protocol_error;

    sdrc_bram_responder #(
        .DepthBitWidth(DW), .RamAddressingMode(MODE), .InitCycles(INIT),
        .ActivateAckDelay(AAD), .ReadLatency(RL), .WriteAckDelay(WAD), .MemoryInitFile("")
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .I_sdrc_cmd_en(I_sdrc_cmd_en), .I_sdrc_cmd(I_sdrc_cmd),
        .I_sdrc_precharge_ctrl(I_sdrc_precharge_ctrl),
        .I_sdram_power_down(I_sdram_power_down), .I_sdram_selfrefresh(I_sdram_selfrefresh),
        .I_sdrc_addr(I_sdrc_addr), .I_sdrc_dqm(I_sdrc_dqm), .I_sdrc_data(I_sdrc_data),
        .I_sdrc_data_len(I_sdrc_data_len), .O_sdrc_data(O_sdrc_data),
        .O_sdrc_init_done(O_sdrc_init_done), .O_sdrc_cmd_ack(O_sdrc_cmd_ack),
        .protocol_error(protocol_error)
    );

    always #5 clk = ~clk;

    // Cycle 0 is the cycle in which rst_n is released.
    int cyc = 0;
    always @(posedge clk) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } beat_t;

    typedef struct {
        logic [2:0]  cmd;
        logic [20:0] addr;
        logic [7:0]  len;
        bit          prech;
        logic [3:0]  dqm;
        logic [31:0] dbase;
        bit          exp_err;
    } vec_t;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] model [DEPTH];
    bit          row_open = 1'b0;
    int          err_cyc = NEVER;
    beat_t       rd_q[$];
    int          ack_q[$];
    vec_t        vecs[16];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void note_err(input int c);
        if (c < err_cyc) err_cyc = c;
    endfunction

    function automatic void model_write(input logic [DW-1:0] wi, input logic [31:0] d, input logic [3:0] m);
        for (int b = 0; b < 4; b++) begin
            if (!m[b]) model[wi][8*b +: 8] = d[8*b +: 8];
        end
    endfunction

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (rst_n) begin
                bit    exp_ack;
                beat_t b;
                exp_ack = (ack_q.size() > 0) && (ack_q[0] == cyc);
                if (exp_ack) void'(ack_q.pop_front());
                chk("cmd_ack", {31'b0, O_sdrc_cmd_ack}, {31'b0, exp_ack});
                chk("init_done", {31'b0, O_sdrc_init_done}, {31'b0, (cyc >= INIT)});
                chk("protocol_error", {31'b0, protocol_error}, {31'b0, (cyc >= err_cyc)});
                if (rd_q.size() > 0 && rd_q[0].cyc == cyc) begin
                    b = rd_q.pop_front();
                    chk("read_beat", O_sdrc_data, b.data);
                end
            end
        end
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic do_reset(input bit check_now);
        #2;
        rst_n = 1'b0;
        I_sdrc_cmd_en = 1'b0;
        rd_q.delete();
        ack_q.delete();
        row_open = 1'b0;
        err_cyc = NEVER;
        #1;
        if (check_now) begin
            chk("reset_data", O_sdrc_data, 32'h0);
            chk("reset_flags", {29'b0, O_sdrc_init_done, O_sdrc_cmd_ack, protocol_error}, 32'h0);
        end
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // Drives one command at a negedge of an Idle cycle and returns once the DUT is Idle again.
    // inj >= 0 drops an illegal write onto the bus inj cycles after acceptance.
    task automatic do_cmd(input logic [2:0] cmd, input logic [20:0] addr, input logic [7:0] len,
                          input bit prech, input logic [3:0] dqm, input logic [31:0] dbase, input int inj);
        int a, idx, done;
        logic [DW-1:0] wi;
        a   = cyc;
        idx = int'(addr >> (2 - MODE)) & (DEPTH - 1);
        I_sdrc_cmd_en = 1'b1;
        I_sdrc_cmd = cmd;
        I_sdrc_addr = addr;
        I_sdrc_data_len = len;
        I_sdrc_precharge_ctrl = prech;
        I_sdrc_dqm = dqm;
        I_sdrc_data = dbase;
        case (cmd)
            C_WR: begin
                if (!row_open) note_err(a + 1);
                for (int k = 0; k <= int'(len); k++) begin
                    if (k > 0) begin
                        @(negedge clk);
                        I_sdrc_cmd_en = 1'b0;
                        I_sdrc_data = dbase + 32'(k);
                    end
                    wi = DW'(idx + k);
                    model_write(wi, I_sdrc_data, dqm);
                end
                if (prech) row_open = 1'b0;
                ack_q.push_back(a + int'(len) + WAD);
                done = a + int'(len) + WAD + 1;
            end
            C_RD: begin
                if (!row_open) note_err(a + 1);
                for (int k = 0; k <= int'(len); k++) begin
                    wi = DW'(idx + k);
                    rd_q.push_back('{a + RL + k, model[wi]});
                end
                if (prech) row_open = 1'b0;
                done = a + RL + int'(len) + 1;
            end
            C_ACT: begin
                if (row_open) note_err(a + 1);
                row_open = 1'b1;
                ack_q.push_back(a + AAD);
                done = a + AAD + 1;
            end
            default: begin
                if (cmd == C_REF) row_open = 1'b0;
                ack_q.push_back(a + AAD);
                done = a + AAD + 1;
            end
        endcase
        if (cyc == a) @(negedge clk);
        I_sdrc_cmd_en = 1'b0;
        if (inj >= 0) begin
            wait_cyc(a + inj);
            I_sdrc_cmd_en = 1'b1;
            I_sdrc_cmd = C_WR;
            I_sdrc_data_len = 8'd0;
            I_sdrc_data = 32'hDEADBEEF;
            note_err(a + inj + 1);
            @(negedge clk);
            I_sdrc_cmd_en = 1'b0;
        end
        wait_cyc(done);
    endtask

    initial begin
        int a;
        vecs[0]  = '{C_ACT,  21'h040, 8'd0, 1'b0, 4'h0, 32'h0,        1'b0};
        vecs[1]  = '{C_WR,   21'h040, 8'd7, 1'b1, 4'h0, 32'hA0,       1'b0};
        vecs[2]  = '{C_ACT,  21'h040, 8'd0, 1'b0, 4'h0, 32'h0,        1'b0};
        vecs[3]  = '{C_RD,   21'h040, 8'd7, 1'b0, 4'h0, 32'h0,        1'b0};
        vecs[4]  = '{C_REF,  21'h000, 8'd0, 1'b0, 4'h0, 32'h0,        1'b0};
        vecs[5]  = '{C_ACT,  21'h000, 8'd0, 1'b0, 4'h0, 32'h0,        1'b0};
        vecs[6]  = '{C_WR,   21'h000, 8'd0, 1'b0, 4'h0, 32'h11223344, 1'b0};
        vecs[7]  = '{C_WR,   21'h000, 8'd0, 1'b0, 4'h5, 32'hFFFFFFFF, 1'b0};
        vecs[8]  = '{C_RD,   21'h000, 8'd0, 1'b0, 4'h0, 32'h0,        1'b0};
        vecs[9]  = '{3'b110, 21'h000, 8'd0, 1'b0, 4'h0, 32'h0,        1'b0};
        vecs[10] = '{C_RD,   21'h040, 8'd7, 1'b1, 4'h0, 32'h0,        1'b0};
        vecs[11] = '{C_ACT,  21'h3FE, 8'd0, 1'b0, 4'h0, 32'h0,        1'b0};
        vecs[12] = '{C_WR,   21'h3FE, 8'd3, 1'b0, 4'h0, 32'hB0,       1'b0};
        vecs[13] = '{C_RD,   21'h3FE, 8'd3, 1'b1, 4'h0, 32'h0,        1'b0};
        vecs[14] = '{C_ACT,  21'h001, 8'd0, 1'b0, 4'h0, 32'h0,        1'b0};
        vecs[15] = '{C_RD,   21'h001, 8'd0, 1'b1, 4'h0, 32'h0,        1'b0};

        fork
            monitor();
        join_none

        // Power-on reset, then a refresh accepted in cycle 20.
        repeat (2) @(negedge clk);
        chk("por_data", O_sdrc_data, 32'h0);
        chk("por_flags", {29'b0, O_sdrc_init_done, O_sdrc_cmd_ack, protocol_error}, 32'h0);
        #2;
        rst_n = 1'b1;
        wait_cyc(20);
        do_cmd(C_REF, 21'h0, 8'd0, 1'b0, 4'h0, 32'h0, -1);

        for (int i = 0; i < 16; i++) begin
            do_cmd(vecs[i].cmd, vecs[i].addr, vecs[i].len, vecs[i].prech, vecs[i].dqm, vecs[i].dbase, -1);
            chk("vec_error", {31'b0, protocol_error}, {31'b0, vecs[i].exp_err});
        end

        // A write dropped onto an active read burst is ignored and flagged.
        do_cmd(C_ACT, 21'h040, 8'd0, 1'b0, 4'h0, 32'h0, -1);
        do_cmd(C_RD, 21'h040, 8'd7, 1'b1, 4'h0, 32'h0, RL + 2);
        do_cmd(C_ACT, 21'h040, 8'd0, 1'b0, 4'h0, 32'h0, -1);
        do_cmd(C_RD, 21'h040, 8'd7, 1'b1, 4'h0, 32'h0, -1);

        // Reset clears the flag but not memory; a read with no activate is flagged yet served.
        do_reset(1'b1);
        wait_cyc(INIT + 1);
        do_cmd(C_RD, 21'h040, 8'd7, 1'b0, 4'h0, 32'h0, -1);

        // Reset asserted during beat 3 of a write: beats 0..2 land, 3..7 keep old data.
        do_reset(1'b1);
        wait_cyc(INIT + 1);
        do_cmd(C_ACT, 21'h040, 8'd0, 1'b0, 4'h0, 32'h0, -1);
        a = cyc;
        I_sdrc_cmd_en = 1'b1;
        I_sdrc_cmd = C_WR;
        I_sdrc_addr = 21'h040;
        I_sdrc_data_len = 8'd7;
        I_sdrc_precharge_ctrl = 1'b0;
        I_sdrc_dqm = 4'h0;
        I_sdrc_data = 32'hC0;
        model_write(DW'(32'h40), 32'hC0, 4'h0);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            I_sdrc_cmd_en = 1'b0;
            I_sdrc_data = 32'hC0 + 32'(k);
            if (k < 3) model_write(DW'(32'h40 + k), I_sdrc_data, 4'h0);
        end
        chk("midburst_cycle", cyc, a + 3);
        do_reset(1'b1);
        wait_cyc(INIT + 1);
        do_cmd(C_ACT, 21'h040, 8'd0, 1'b0, 4'h0, 32'h0, -1);
        do_cmd(C_RD, 21'h040, 8'd7, 1'b1, 4'h0, 32'h0, -1);
        chk("merged_beat2", model[DW'(32'h42)], 32'hC2);
        chk("merged_beat3", model[DW'(32'h43)], 32'hA3);

        // Power-down request is unsupported and flagged.
        I_sdram_power_down = 1'b1;
        note_err(cyc + 1);
        @(negedge clk);
        I_sdram_power_down = 1'b0;
        repeat (4) @(negedge clk);

        chk("scoreboard_drained", 32'(rd_q.size() + ack_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
